// File: rtl/alu_mp_sequencer_pkg.sv
// rtl/alu_mp_sequencer_pkg.sv - shared ALU op and sequencer state encodings
package alu_mp_sequencer_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOT = 3'b100,
        ALU_XOR = 3'b101,
        ALU_NEG = 3'b110,
        ALU_SHL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        DONE  = 2'b11
    } state_e;

    // Ops whose per-nibble carry/borrow must be folded into the next nibble.
    function automatic logic needs_fixup(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_NEG) || (op == ALU_SHL);
    endfunction

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// rtl/alu_mp_sequencer_if.sv - request/response handshake bundle
interface alu_mp_sequencer_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry
    );

endinterface

// File: rtl/alu_mp_sequencer_alux4.sv
// rtl/alu_mp_sequencer_alux4.sv - 4-bit combinational ALU without carry-in
module alu_mp_sequencer_alux4
    import alu_mp_sequencer_pkg::*;
(
    input  alu_op_e    op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y,
    output logic       cout
);

    always_comb begin
        y    = 4'd0;
        cout = 1'b0;
        case (op)
            ALU_ADD: {cout, y} = {1'b0, a} + {1'b0, b};
            ALU_SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOT: y = ~a;
            ALU_XOR: y = a ^ b;
            ALU_NEG: begin
                y    = 4'd0 - a;
                cout = (a != 4'd0);
            end
            ALU_SHL: begin
                y    = {a[2:0], 1'b0};
                cout = a[3];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mp_sequencer.sv
// rtl/alu_mp_sequencer.sv - multi-precision ops sequenced nibble by nibble over one ALUx4
module alu_mp_sequencer
    import alu_mp_sequencer_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_mp_sequencer_if.slave  bus
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e        state_q, state_d;
    alu_op_e       op_q, op_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [W-1:0]  rsp_result_q, rsp_result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cin_q, cin_d, c1_q, c1_d, rsp_carry_q, rsp_carry_d;

    logic [3:0]    a_nib, b_nib, r_nib;
    alu_op_e       alu_op;
    logic [3:0]    alu_a, alu_b, alu_y;
    logic          alu_cout;
    logic          do_adv, cin_next;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign r_nib = res_q[{idx_q, 2'b00} +: 4];

    // PASS2 folds the incoming carry/borrow into the partial nibble already stored.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = a_nib;
        alu_b  = b_nib;
        if (state_q == PASS2) begin
            alu_a = r_nib;
            alu_b = 4'd1;
            case (op_q)
                ALU_ADD: alu_op = ALU_ADD;
                ALU_SHL: alu_op = ALU_OR;
                default: alu_op = ALU_SUB;
            endcase
        end else if (op_q == ALU_NEG) begin
            alu_op = ALU_SUB;
            alu_a  = 4'd0;
            alu_b  = a_nib;
        end else begin
            alu_op = op_q;
        end
    end

    alu_mp_sequencer_alux4 u_alu (
        .op   (alu_op),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        rsp_result_d = rsp_result_q;
        idx_d        = idx_q;
        cin_d        = cin_q;
        c1_d         = c1_q;
        rsp_carry_d  = rsp_carry_q;
        do_adv       = 1'b0;
        cin_next     = cin_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = alu_op_e'(bus.req_op);
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    res_d   = '0;
                    idx_d   = '0;
                    cin_d   = 1'b0;
                    c1_d    = 1'b0;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                res_d[{idx_q, 2'b00} +: 4] = alu_y;
                c1_d = alu_cout;
                if (cin_q && needs_fixup(op_q)) begin
                    state_d = PASS2;
                end else begin
                    cin_next = alu_cout;
                    do_adv   = 1'b1;
                end
            end
            PASS2: begin
                res_d[{idx_q, 2'b00} +: 4] = alu_y;
                cin_next = c1_q | alu_cout;
                do_adv   = 1'b1;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_adv) begin
            cin_d = cin_next;
            if (idx_q == LAST) begin
                rsp_result_d = res_d;
                rsp_carry_d  = needs_fixup(op_q) ? cin_next : 1'b0;
                state_d      = DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = PASS1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= ALU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            rsp_result_q <= '0;
            idx_q        <= '0;
            cin_q        <= 1'b0;
            c1_q         <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            rsp_result_q <= rsp_result_d;
            idx_q        <= idx_d;
            cin_q        <= cin_d;
            c1_q         <= c1_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb/tb_alu_mp_sequencer.sv - vector table, random model checks and corner sequences
module tb_alu_mp_sequencer;

    localparam int N = 2;
    localparam int W = 4 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mp_sequencer_if #(.NIBBLES(N)) bus ();

    alu_mp_sequencer #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         carry;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e);
        logic [W:0] s;
        int f;
        int m;
        f = 0;
        e.carry = 1'b0;
        case (op)
            3'b000: begin
                s       = {1'b0, a} + {1'b0, b};
                e.res   = s[W-1:0];
                e.carry = s[W];
            end
            3'b001: begin
                e.res   = a - b;
                e.carry = (a < b);
            end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: e.res = ~a;
            3'b101: e.res = a ^ b;
            3'b110: begin
                e.res   = {W{1'b0}} - a;
                e.carry = (a != 0);
            end
            default: begin
                e.res   = {a[W-2:0], 1'b0};
                e.carry = a[W-1];
            end
        endcase
        for (int i = 1; i < N; i++) begin
            m = (1 << (4 * i)) - 1;
            case (op)
                3'b000: if ((((int'(a) & m) + (int'(b) & m)) >> (4 * i)) != 0) f++;
                3'b001: if ((int'(a) & m) < (int'(b) & m)) f++;
                3'b110: if ((int'(a) & m) != 0) f++;
                3'b111: if (a[4*i-1]) f++;
                default: ;
            endcase
        end
        e.lat = N + f;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e, input int hold);
        exp_t x;
        int   lat;
        int   guard;
        sb.push_back(e);
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, " idle"}, 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = (hold == 0);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        lat = 0;
        while (!bus.rsp_valid && lat < 4 * N + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        x = sb.pop_front();
        chk({name, " result"}, 32'(bus.rsp_result), 32'(x.res));
        chk({name, " carry"}, 32'(bus.rsp_carry), 32'(x.carry));
        chk({name, " latency"}, 32'(lat), 32'(x.lat));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, " held"}, 32'({bus.rsp_valid, bus.req_ready, bus.rsp_carry, bus.rsp_result}),
                32'({1'b1, 1'b0, x.carry, x.res}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, " released"}, 32'({bus.rsp_valid, bus.req_ready, bus.rsp_carry, bus.rsp_result}),
            32'({1'b0, 1'b1, x.carry, x.res}));
    endtask

    initial begin
        exp_t e;
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        tbl[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 3};
        tbl[1]  = '{3'b001, 8'h10, 8'h01, 8'h0F, 1'b0, 3};
        tbl[2]  = '{3'b001, 8'h01, 8'h02, 8'hFF, 1'b1, 3};
        tbl[3]  = '{3'b110, 8'h01, 8'h77, 8'hFF, 1'b1, 3};
        tbl[4]  = '{3'b110, 8'h00, 8'h55, 8'h00, 1'b0, 2};
        tbl[5]  = '{3'b111, 8'h88, 8'h00, 8'h10, 1'b1, 3};
        tbl[6]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 2};
        tbl[7]  = '{3'b100, 8'hA5, 8'hFF, 8'h5A, 1'b0, 2};
        tbl[8]  = '{3'b011, 8'h0F, 8'hA0, 8'hAF, 1'b0, 2};
        tbl[9]  = '{3'b101, 8'hFF, 8'h0F, 8'hF0, 1'b0, 2};
        tbl[10] = '{3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 2};

        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_result}),
            32'({1'b1, 1'b0, 1'b0, {W{1'b0}}}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            e.res   = tbl[i].res;
            e.carry = tbl[i].carry;
            e.lat   = tbl[i].lat;
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e, 0);
        end

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            model(rop, ra, rb, e);
            run_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, e, int'($urandom_range(0, 2)));
        end

        // Backpressure: response must sit still while the consumer stalls.
        e = '{8'h10, 1'b0, 3};
        run_op("backpressure", 3'b000, 8'h0F, 8'h01, e, 5);
        e = '{8'h30, 1'b0, 2};
        run_op("after backpressure", 3'b011, 8'h10, 8'h20, e, 0);

        // Reset while the second nibble's fixup pass is in flight.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b001;
        bus.req_a     = 8'h10;
        bus.req_b     = 8'h01;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'({bus.req_ready, bus.rsp_valid}), 32'({1'b0, 1'b0}));
        rst_n = 1'b0;
        #1;
        chk("mid-op reset", 32'({bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_result}),
            32'({1'b1, 1'b0, 1'b0, {W{1'b0}}}));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("no response after reset", 32'({bus.req_ready, bus.rsp_valid}), 32'({1'b1, 1'b0}));
        end
        e = '{8'h46, 1'b0, 2};
        run_op("post-reset add", 3'b000, 8'h12, 8'h34, e, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
